// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FIFO entry type and the default reset PC for the
// instruction fetch stage.
//   INST_W  - instruction word width
//   PC_W    - byte program-counter width
//   MEM_LAT - fixed read latency of memory port 0, in cycles
package fetch_pkg;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned MEM_LAT = 2;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Instructions are halfword aligned, so bit 0 of any byte PC is forced to 0.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the memory read port 0, redirect request and the decode
// handshake of the fetch stage.
//   mem_raddr      - word address [15:1] to memory read port 0
//   mem_rdata      - memory read data, valid MEM_LAT cycles after the address
//   redirect_valid - one-cycle flush-and-restart pulse
//   redirect_pc    - restart byte PC (bit 0 ignored)
//   inst_valid     - inst_data/inst_pc hold a valid instruction
//   inst_ready     - decode accepts the current instruction
//   inst_data      - instruction word
//   inst_pc        - byte PC of inst_data
// modport master: the fetch unit; modport slave: memory/decode/branch side.
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-2:0]   mem_raddr;
  logic [INST_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output mem_raddr, inst_valid, inst_data, inst_pc,
    input  mem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_raddr, inst_valid, inst_data, inst_pc,
    output mem_rdata, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t used to buffer returned
// instruction words against decode back-pressure.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_entry at the tail
//   i_pop      - drop the head entry (ignored when empty)
//   i_flush    - empty the FIFO; wins over push and pop
//   i_entry    - entry to write
//   o_count    - number of stored entries
//   o_empty    - no entries stored
//   o_head     - head entry, all zero while empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_entry,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output fetch_entry_t           o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of memory read port 0. Issues
// one word read per cycle, tracks the two reads in the memory pipeline and
// buffers returned words so decode stalls never lose data. A redirect flushes
// everything in flight and buffered and restarts at the new PC.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   fif   - fetch_if.master: memory port, redirect, decode handshake
// Parameters: RESET_PC (first byte PC after reset, bit 0 ignored),
//             DEPTH (output FIFO entries, power of 2, >= 4).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  fif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_W-1:0] r_pc;
  logic            r_v0;
  logic [PC_W-1:0] r_pc0;
  logic            r_v1;
  logic [PC_W-1:0] r_pc1;

  logic [AW:0]     w_count;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;
  logic [AW+1:0]   w_occ;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;

  // Buffered plus in-flight words; a pop this cycle is deliberately not
  // credited, so the FIFO can never be overrun by words already requested.
  assign w_occ   = (AW+2)'(w_count) + (AW+2)'(r_v0) + (AW+2)'(r_v1);
  assign w_issue = !fif.redirect_valid && (w_occ < (AW+2)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= pc_align(RESET_PC);
      r_v0  <= 1'b0;
      r_pc0 <= '0;
      r_v1  <= 1'b0;
      r_pc1 <= '0;
    end else begin
      if (fif.redirect_valid) begin
        r_pc <= pc_align(fif.redirect_pc);
      end else if (w_issue) begin
        r_pc <= r_pc + 16'd2;
      end
      // Stage 1 is the cycle the memory presents that word on mem_rdata.
      r_v0  <= w_issue;
      r_pc0 <= r_pc;
      r_v1  <= r_v0 && !fif.redirect_valid;
      r_pc1 <= r_pc0;
    end
  end

  assign w_push        = r_v1;
  assign w_pop         = !w_empty && fif.inst_ready;
  assign w_entry.inst  = fif.mem_rdata;
  assign w_entry.pc    = r_pc1;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (fif.redirect_valid),
    .i_entry (w_entry),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign fif.mem_raddr  = r_pc[PC_W-1:1];
  assign fif.inst_valid = !w_empty;
  assign fif.inst_data  = w_head.inst;
  assign fif.inst_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A 2-cycle memory model
// returns 16'hA000 + word address; a scoreboard queue holds the expected
// instruction stream from each restart point and is compared on every
// transfer. A vector table covers redirects; hand sequences cover reset
// latency, back-pressure, flush with work in flight, back-to-back redirects
// and asynchronous reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if fif ();

  fetch_unit #(
    .RESET_PC (16'h0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return 16'hA000 + {1'b0, a};
  endfunction

  // Memory read port 0: address sampled at the edge, data one edge later.
  logic [14:0] r_a1;
  always @(posedge clk) begin
    r_a1          <= fif.mem_raddr;
    fif.mem_rdata <= mem_word(r_a1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  fetch_entry_t sb_q[$];

  task automatic sb_start(input logic [15:0] p);
    logic [15:0]  a;
    fetch_entry_t e;
    sb_q.delete();
    a = {p[15:1], 1'b0};
    for (int k = 0; k < 200; k++) begin
      e.inst = mem_word(a[15:1]);
      e.pc   = a;
      sb_q.push_back(e);
      a = a + 16'd2;
    end
  endtask

  // Transfer monitor, hold-stability check and overflow guard.
  logic         prev_hold = 1'b0;
  fetch_entry_t prev_e;
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, fif.inst_valid}, 32'd1);
        check("hold_word", {fif.inst_data, fif.inst_pc}, {prev_e.inst, prev_e.pc});
      end
      if (fif.inst_valid && fif.inst_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h, expected no transfer", fif.inst_pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", {16'd0, fif.inst_pc}, {16'd0, e.pc});
          check("sb_data", {16'd0, fif.inst_data}, {16'd0, e.inst});
        end
      end
      check("no_overflow", {31'd0, (dut.u_fifo.r_count <= DEPTH)}, 32'd1);
      prev_hold   = fif.inst_valid && !fif.inst_ready && !fif.redirect_valid;
      prev_e.inst = fif.inst_data;
      prev_e.pc   = fif.inst_pc;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // One cycle = from just after a rising edge to just after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.inst_ready = ready;
    step();
    step();
    sb_q.delete();
    rst_n = 1'b1;
    sb_start(16'h0000);
  endtask

  task automatic redirect(input logic [15:0] p);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = p;
    step();
    fif.redirect_valid = 1'b0;
    sb_start(p);
  endtask

  task automatic expect_valid(input string name, input logic v);
    check(name, {31'd0, fif.inst_valid}, {31'd0, v});
  endtask

  typedef struct {
    logic [15:0] target;
    logic        rand_ready;
    logic [15:0] exp_first;
    int unsigned run;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{target: 16'h0100, rand_ready: 1'b0, exp_first: 16'h0100, run: 8};
    vecs[1] = '{target: 16'hFFFC, rand_ready: 1'b0, exp_first: 16'hFFFC, run: 8};
    vecs[2] = '{target: 16'h1235, rand_ready: 1'b1, exp_first: 16'h1234, run: 30};
    vecs[3] = '{target: 16'h7FFE, rand_ready: 1'b1, exp_first: 16'h7FFE, run: 30};
    vecs[4] = '{target: 16'h0000, rand_ready: 1'b0, exp_first: 16'h0000, run: 8};

    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    fif.inst_ready     = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, fif.inst_valid}, 32'd0);
    check("rst_word", {fif.inst_data, fif.inst_pc}, 32'd0);
    check("rst_raddr", {17'd0, fif.mem_raddr}, 32'd0);
    step();

    // Reset release: first instruction in cycle 3, then one per cycle.
    do_reset(1'b1);
    check("t1_raddr_c0", {17'd0, fif.mem_raddr}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      expect_valid("t1_early", 1'b0);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      expect_valid("t1_stream_valid", 1'b1);
      check("t1_stream_pc", {16'd0, fif.inst_pc}, 32'(2 * k));
      check("t1_stream_data", {16'd0, fif.inst_data}, 32'(16'hA000 + k));
      step();
    end

    // Back-pressure from cycle 0: exactly DEPTH words captured.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) step();
    check("t2_raddr_c4", {17'd0, fif.mem_raddr}, 32'd4);
    for (int c = 4; c < 10; c++) step();
    check("t2_raddr_c10", {17'd0, fif.mem_raddr}, 32'd4);
    expect_valid("t2_valid_c10", 1'b1);
    check("t2_head_c10", {16'd0, fif.inst_pc}, 32'd0);
    fif.inst_ready = 1'b1;
    for (int c = 10; c < 14; c++) step();
    expect_valid("t2_valid_c14", 1'b1);
    check("t2_pc_c14", {16'd0, fif.inst_pc}, 32'd8);
    for (int c = 14; c < 20; c++) step();

    // Redirect with two buffered words and two reads in flight.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) step();
    expect_valid("t3_pre_valid", 1'b1);
    redirect(16'h0100);
    fif.inst_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      expect_valid("t3_flush_gap", 1'b0);
      step();
    end
    expect_valid("t3_r4_valid", 1'b1);
    check("t3_r4_pc", {16'd0, fif.inst_pc}, 32'h0100);
    check("t3_r4_data", {16'd0, fif.inst_data}, 32'(mem_word(15'h0080)));
    for (int c = 0; c < 6; c++) step();

    // Back-to-back redirects: only the last stream is delivered.
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 16'h0200;
    step();
    sb_start(16'h0200);
    redirect(16'h0300);
    for (int c = 2; c < 5; c++) begin
      expect_valid("t4_gap", 1'b0);
      step();
    end
    expect_valid("t4_r5_valid", 1'b1);
    check("t4_r5_pc", {16'd0, fif.inst_pc}, 32'h0300);
    for (int c = 0; c < 6; c++) step();

    // Redirect vector table.
    for (int v = 0; v < 5; v++) begin
      redirect(vecs[v].target);
      fif.inst_ready = 1'b1;
      for (int c = 1; c < 4; c++) begin
        expect_valid("vec_gap", 1'b0);
        step();
      end
      expect_valid("vec_first_valid", 1'b1);
      check("vec_first_pc", {16'd0, fif.inst_pc}, {16'd0, vecs[v].exp_first});
      if (!vecs[v].rand_ready) begin
        for (int k = 0; k < 4; k++) begin
          expect_valid("vec_contig_valid", 1'b1);
          check("vec_contig_pc", {16'd0, fif.inst_pc}, {16'd0, vecs[v].exp_first + 16'(2 * k)});
          step();
        end
      end
      for (int c = 0; c < int'(vecs[v].run); c++) begin
        if (vecs[v].rand_ready) fif.inst_ready = 1'($urandom_range(0, 1));
        step();
      end
    end

    // Asynchronous reset with the FIFO full.
    fif.inst_ready = 1'b0;
    redirect(16'h0040);
    for (int c = 0; c < 10; c++) step();
    expect_valid("t6_full_valid", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, fif.inst_valid}, 32'd0);
    check("t6_async_word", {fif.inst_data, fif.inst_pc}, 32'd0);
    check("t6_async_raddr", {17'd0, fif.mem_raddr}, 32'd0);
    step();
    step();
    sb_q.delete();
    fif.inst_ready = 1'b1;
    rst_n = 1'b1;
    sb_start(16'h0000);
    for (int c = 0; c < 3; c++) begin
      expect_valid("t6_restart_gap", 1'b0);
      step();
    end
    expect_valid("t6_restart_valid", 1'b1);
    check("t6_restart_pc", {16'd0, fif.inst_pc}, 32'd0);
    check("t6_restart_data", {16'd0, fif.inst_data}, 32'hA000);
    for (int c = 0; c < 5; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
